// File: rtl/ht_pkg.sv
// Shared constants and types for the Hilbert-transform coefficient receiver.
// The taps, state encoding and coefficient type are shared by the bank and the FIR top.
package ht_pkg;

  localparam int HT_LENGTH      = 27;
  localparam int HT_COEFF_WIDTH = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } ht_state_t;

  typedef logic signed [HT_COEFF_WIDTH-1:0] ht_coeff_t;

endpackage

// File: rtl/ht_coeff_bank.sv
// Local coefficient register file: one indexed write port, all taps read in parallel.
// The bank is cleared only by reset, so a faulted load leaves what was written.
module ht_coeff_bank
  import ht_pkg::*;
#(
  parameter int LENGTH = HT_LENGTH,
  parameter int WIDTH  = HT_COEFF_WIDTH,
  parameter int IW     = $clog2(LENGTH)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           we,
  input  logic [IW-1:0]                  index,
  input  logic [WIDTH-1:0]               data,
  output logic [LENGTH-1:0][WIDTH-1:0]   coeffs
);

  logic [LENGTH-1:0][WIDTH-1:0] mem_r;

  // Coefficient storage with indexed write
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_r <= '0;
    end else if (we) begin
      mem_r[index] <= data;
    end
  end

  assign coeffs = mem_r;

endmodule

// File: rtl/ht_coeff_fir.sv
// Coefficient-stream receiver and direct-form FIR producing the quadrature branch.
// Loads LENGTH taps from the setup module, then filters with a two-cycle pipeline.
module ht_coeff_fir
  import ht_pkg::*;
#(
  parameter int LENGTH      = HT_LENGTH,
  parameter int COEFF_WIDTH = HT_COEFF_WIDTH,
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         coeffEnable,
  input  logic signed [COEFF_WIDTH-1:0] coefficientIn,
  input  logic                         coeffSetFlag,
  output logic                         coeffLoaded,
  output logic                         loadError,
  input  logic signed [DATA_WIDTH-1:0] dataIn,
  input  logic                         dataInValid,
  output logic signed [OUT_WIDTH-1:0]  dataOut,
  output logic                         dataOutValid
);

  localparam int IW = $clog2(LENGTH);
  localparam int PW = COEFF_WIDTH + DATA_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

  ht_state_t                            state_r, state_s;
  logic [IW-1:0]                        index_r, index_s;
  logic                                 bank_we_s, clear_s, accept_s;
  logic [LENGTH-1:0][COEFF_WIDTH-1:0]   bank_s;
  logic signed [DATA_WIDTH-1:0]         x_r    [LENGTH];
  logic signed [PW-1:0]                 prod_r [LENGTH];
  logic                                 v0_r, v1_r;
  logic signed [OUT_WIDTH-1:0]          sum_s;

  ht_coeff_bank #(.LENGTH(LENGTH), .WIDTH(COEFF_WIDTH), .IW(IW)) u_bank (
    .clock  (clock),
    .reset  (reset),
    .we     (bank_we_s),
    .index  (index_r),
    .data   (coefficientIn),
    .coeffs (bank_s)
  );

  // Load-sequence next-state logic
  always_comb begin
    state_s   = state_r;
    index_s   = index_r;
    bank_we_s = 1'b0;
    clear_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_RUN, ST_FAULT: begin
        if (start) begin
          state_s = ST_REQ;
          clear_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      // Source output lags enable by one edge, so wait once before capturing.
      ST_REQ: begin
        state_s = ST_LOAD;
        index_s = '0;
      end
      ST_LOAD: begin
        bank_we_s = 1'b1;
        index_s   = index_r + IW'(1);
        if (index_r == LAST_IDX) begin
          state_s = coeffSetFlag ? ST_RUN : ST_FAULT;
        end else if (coeffSetFlag) begin
          state_s = ST_FAULT;
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and status outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      index_r     <= '0;
      coeffEnable <= 1'b0;
      coeffLoaded <= 1'b0;
      loadError   <= 1'b0;
    end else begin
      state_r     <= state_s;
      index_r     <= index_s;
      coeffEnable <= (state_s == ST_REQ) || (state_s == ST_LOAD);
      coeffLoaded <= (state_s == ST_RUN);
      loadError   <= (state_s == ST_FAULT);
    end
  end

  assign accept_s = (state_r == ST_RUN) && dataInValid;

  // Adder tree over the registered products, sign-extended to full precision
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LENGTH; i++) begin
      sum_s = sum_s + OUT_WIDTH'(prod_r[i]);
    end
  end

  // Delay line, product stage and output stage
  always_ff @(posedge clock) begin
    if (reset || clear_s) begin
      for (int i = 0; i < LENGTH; i++) begin
        x_r[i]    <= '0;
        prod_r[i] <= '0;
      end
      v0_r         <= 1'b0;
      v1_r         <= 1'b0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
    end else begin
      if (accept_s) begin
        x_r[0] <= dataIn;
        for (int i = 1; i < LENGTH; i++) begin
          x_r[i] <= x_r[i-1];
        end
      end
      for (int i = 0; i < LENGTH; i++) begin
        prod_r[i] <= PW'($signed(bank_s[i])) * PW'(x_r[i]);
      end
      v0_r         <= accept_s;
      v1_r         <= v0_r;
      dataOutValid <= v1_r;
      if (v1_r) begin
        dataOut <= sum_s;
      end
    end
  end

endmodule

// File: tb/tb_ht_coeff_fir.sv
// Scoreboard bench for ht_coeff_fir: a modelled setup module feeds coefficients,
// expected outputs come from the convolution sum over accepted samples.
module tb_ht_coeff_fir;

  localparam int L  = 27;
  localparam int CW = 17;
  localparam int DW = 16;
  localparam int OW = DW + CW + 5;

  logic clock = 1'b0;
  logic reset, start, coeffEnable, coeffSetFlag, coeffLoaded, loadError;
  logic dataInValid, dataOutValid;
  logic signed [CW-1:0] coefficientIn;
  logic signed [DW-1:0] dataIn;
  logic signed [OW-1:0] dataOut;

  int     checks = 0, errors = 0;
  int     src_h [L];
  int     h     [L];
  int     force_idx = -1;
  bit     drop_flag = 1'b0;
  int     src_cnt = 0;
  longint hist[$];
  longint expq[$];
  bit     model_run = 1'b0, hold_chk = 1'b0, have_out = 1'b0;
  longint last_exp = 0;
  int     outs_seen = 0;

  ht_coeff_fir dut (
    .clock(clock), .reset(reset), .start(start), .coeffEnable(coeffEnable),
    .coefficientIn(coefficientIn), .coeffSetFlag(coeffSetFlag),
    .coeffLoaded(coeffLoaded), .loadError(loadError), .dataIn(dataIn),
    .dataInValid(dataInValid), .dataOut(dataOut), .dataOutValid(dataOutValid)
  );

  always #5 clock = ~clock;

  // Setup module model: registers coeff[n] one edge after seeing enable
  always @(posedge clock) begin
    if (reset || !coeffEnable) begin
      src_cnt       <= 0;
      coefficientIn <= '0;
      coeffSetFlag  <= 1'b0;
    end else begin
      if (src_cnt < L) coefficientIn <= src_h[src_cnt][CW-1:0];
      else             coefficientIn <= '0;
      coeffSetFlag <= (src_cnt == force_idx) || (src_cnt == L-1 && !drop_flag);
      src_cnt      <= src_cnt + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < L && k < hist.size(); k++) s += longint'(h[k]) * hist[k];
    return s;
  endfunction

  task automatic clear_model();
    hist.delete();
    expq.delete();
    have_out = 1'b0;
  endtask

  // Monitor: pop the scoreboard whenever the DUT marks an output valid
  always @(negedge clock) begin
    longint e;
    if (dataOutValid === 1'b1) begin
      outs_seen++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0d required=no_output", longint'(dataOut));
      end else begin
        e = expq.pop_front();
        chk("dataOut", longint'(dataOut), e);
        last_exp = e;
        have_out = 1'b1;
      end
    end else if (hold_chk && have_out) begin
      chk("dataOut_hold", longint'(dataOut), last_exp);
    end
  end

  task automatic drive(input bit v, input longint d);
    dataInValid = v;
    dataIn      = d[DW-1:0];
    if (v && model_run) begin
      hist.push_front(longint'($signed(d[DW-1:0])));
      if (hist.size() > L) void'(hist.pop_back());
      expq.push_back(model_y());
    end
    @(negedge clock);
  endtask

  task automatic rand_coeffs();
    for (int i = 0; i < L; i++) src_h[i] = int'($urandom_range(0, 131071)) - 65536;
  endtask

  task automatic do_load(input int fidx, input bit drop, input bit extra_start,
                         output int en_cnt, output int done_n, output bit ok);
    force_idx = fidx;
    drop_flag = drop;
    model_run = 1'b0;
    hold_chk  = 1'b0;
    clear_model();
    start = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    en_cnt = 0;
    done_n = 0;
    ok     = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (coeffEnable) en_cnt++;
      start = (extra_start && n == 5);
      if (coeffLoaded || loadError) begin
        done_n = n;
        ok     = coeffLoaded;
        break;
      end
      @(negedge clock);
    end
    start = 1'b0;
    chk("load_finished", longint'(done_n != 0), 1);
    if (ok) begin
      h = src_h;
      model_run = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_coeffEnable"}, longint'(coeffEnable), 0);
    chk({tag, "_coeffLoaded"}, longint'(coeffLoaded), 0);
    chk({tag, "_loadError"}, longint'(loadError), 0);
    chk({tag, "_dataOut"}, longint'(dataOut), 0);
    chk({tag, "_dataOutValid"}, longint'(dataOutValid), 0);
  endtask

  initial begin
    int en_cnt, done_n, outs;
    bit ok;
    reset = 1'b1; start = 1'b0; dataInValid = 1'b0; dataIn = '0;
    rand_coeffs();
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Good load with a stray start mid-LOAD that must be ignored
    do_load(-1, 1'b0, 1'b1, en_cnt, done_n, ok);
    chk("load_en_cycles", en_cnt, L + 1);
    chk("load_done_cycle", done_n, L + 2);
    chk("load_ok", longint'(ok), 1);
    chk("load_no_error", longint'(loadError), 0);

    // Impulse reproduces the bank, then zeros
    drive(1'b1, 1);
    repeat (30) drive(1'b1, 0);
    repeat (4) drive(1'b0, 0);
    chk("impulse_drained", expq.size(), 0);

    // Random samples with random valid gaps
    hold_chk = 1'b1;
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 3) != 0, longint'(int'($urandom_range(0, 65535)) - 32768));
    repeat (4) drive(1'b0, 0);
    hold_chk = 1'b0;
    chk("random_drained", expq.size(), 0);

    // Full-scale step through large antisymmetric taps
    for (int k = 0; k < 13; k++) begin
      src_h[k]      = -(65535 - 7 * k);
      src_h[L-1-k]  = 65535 - 7 * k;
    end
    src_h[13] = 0;
    do_load(-1, 1'b0, 1'b0, en_cnt, done_n, ok);
    chk("step_load_ok", longint'(ok), 1);
    repeat (30) drive(1'b1, -32768);
    repeat (4) drive(1'b0, 0);
    chk("step_steady", longint'(dataOut), 0);

    // Early end-of-stream flag at index 10
    rand_coeffs();
    do_load(10, 1'b0, 1'b0, en_cnt, done_n, ok);
    chk("early_done_cycle", done_n, 13);
    chk("early_en_cycles", en_cnt, 12);
    chk("early_loadError", longint'(loadError), 1);
    chk("early_coeffEnable", longint'(coeffEnable), 0);
    chk("early_coeffLoaded", longint'(coeffLoaded), 0);
    outs = outs_seen;
    for (int i = 0; i < 10; i++) drive(1'b1, longint'($urandom_range(0, 1000)));
    repeat (3) drive(1'b0, 0);
    chk("fault_ignores_data", outs_seen, outs);

    // Reload after fault, short random run
    rand_coeffs();
    do_load(-1, 1'b0, 1'b0, en_cnt, done_n, ok);
    chk("reload_ok", longint'(ok), 1);
    chk("reload_en_cycles", en_cnt, L + 1);
    for (int i = 0; i < 40; i++) drive(1'b1, longint'(int'($urandom_range(0, 65535)) - 32768));
    repeat (4) drive(1'b0, 0);
    chk("reload_drained", expq.size(), 0);

    // Missing end-of-stream flag
    do_load(-1, 1'b1, 1'b0, en_cnt, done_n, ok);
    chk("missing_done_cycle", done_n, L + 2);
    chk("missing_loadError", longint'(loadError), 1);
    repeat (5) @(negedge clock);
    chk("missing_never_run", longint'(coeffLoaded), 0);
    drop_flag = 1'b0;

    // Reset while capturing index 13
    force_idx = -1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("rst_load");
    reset = 1'b0;
    model_run = 1'b0;
    clear_model();
    outs = outs_seen;
    for (int i = 0; i < 5; i++) drive(1'b1, 5);
    repeat (3) drive(1'b0, 0);
    chk("idle_ignores_data", outs_seen, outs);

    // Reset while an output is valid in RUN
    rand_coeffs();
    do_load(-1, 1'b0, 1'b0, en_cnt, done_n, ok);
    chk("pre_rst_run_ok", longint'(ok), 1);
    for (int i = 0; i < 10 && dataOutValid !== 1'b1; i++)
      drive(1'b1, longint'(int'($urandom_range(0, 65535)) - 32768));
    chk("run_output_seen", longint'(dataOutValid), 1);
    reset = 1'b1;
    dataInValid = 1'b0;
    @(negedge clock);
    chk_all_zero("rst_run");
    model_run = 1'b0;
    clear_model();
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst_run_quiet", longint'(dataOutValid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
